// File: rtl/rtc_bus_scheduler_pkg.sv
//==============================================================================
//  Module      : rtc_bus_scheduler_pkg
//  Description : Shared types and constants for the RTC bus scheduler. Holds
//                the sequencer state encoding, the requester indices and the
//                RTC register addresses that the edit and refresh FSMs also use.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rtc_bus_scheduler_pkg;

    // Sequencer states. The encoding is fixed so waveforms read the same
    // across builds.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A_SET = 3'd1,
        S_A_STB = 3'd2,
        S_A_HLD = 3'd3,
        S_D_SET = 3'd4,
        S_D_STB = 3'd5,
        S_D_HLD = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Requester indices. A lower index wins arbitration.
    localparam int c_num_req     = 3;
    localparam int c_req_irq     = 0;
    localparam int c_req_edit    = 1;
    localparam int c_req_refresh = 2;

    // RTC register map shared with the edit and refresh FSMs.
    localparam logic [7:0] c_rtc_addr_sec     = 8'h21;
    localparam logic [7:0] c_rtc_addr_min     = 8'h22;
    localparam logic [7:0] c_rtc_addr_hour    = 8'h23;
    localparam logic [7:0] c_rtc_addr_day     = 8'h24;
    localparam logic [7:0] c_rtc_addr_month   = 8'h25;
    localparam logic [7:0] c_rtc_addr_year    = 8'h26;
    localparam logic [7:0] c_rtc_addr_status  = 8'h00;
    localparam logic [7:0] c_rtc_addr_irq_ack = 8'hF0;

    // Fixed-priority pick among the request lines. Only meaningful when at
    // least one line is high; an all-zero input falls through to the
    // lowest-priority index, which the caller never latches.
    function automatic logic [1:0] pick_winner(input logic [c_num_req-1:0] req);
        logic [1:0] idx;
        if (req[c_req_irq]) begin
            idx = 2'(c_req_irq);
        end else if (req[c_req_edit]) begin
            idx = 2'(c_req_edit);
        end else begin
            idx = 2'(c_req_refresh);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_bus_scheduler_if.sv
//==============================================================================
//  Module      : rtc_bus_scheduler_if
//  Description : Bundles the requester handshake (req/we/addr/wdata ->
//                rdata/done/busy) and the RTC multiplexed-bus pins
//                (AD, CS, RD, RW, Dato_sal drive/sample) of the scheduler.
//                slave  : scheduler view
//                master : requester / board view
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rtc_bus_scheduler_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);

    // Requester side
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [DATA_W-1:0]   rdata;
    logic [2:0]          done;
    logic                busy;

    // RTC chip side
    logic                AD;
    logic                CS;
    logic                RD;
    logic                RW;
    logic [DATA_W-1:0]   dato_out;
    logic                dato_oe;
    logic [DATA_W-1:0]   dato_in;

    modport slave (
        input  req, we, addr, wdata, dato_in,
        output rdata, done, busy, AD, CS, RD, RW, dato_out, dato_oe
    );

    modport master (
        output req, we, addr, wdata, dato_in,
        input  rdata, done, busy, AD, CS, RD, RW, dato_out, dato_oe
    );

endinterface

`default_nettype wire

// File: rtl/rtc_bus_scheduler_phase_timer.sv
//==============================================================================
//  Module      : rtc_bus_scheduler_phase_timer
//  Description : 4-bit down-counter that times one bus phase. Reloaded with
//                T_PH-1 whenever the sequencer changes state, then counts
//                down; o_phase_end is high in the last cycle of the phase.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                i_load           - sequencer is changing state this edge
//                o_phase_end      - count has reached zero
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rtc_bus_scheduler_phase_timer #(
    parameter int T_PH = 4
) (
    input  wire  clk,
    input  wire  rst,
    input  logic i_load,
    output logic o_phase_end
);

    localparam logic [3:0] c_load_val = 4'(T_PH - 1);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_phase_end = (r_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_scheduler.sv
//==============================================================================
//  Module      : rtc_bus_scheduler
//  Description : Sole master of the RTC multiplexed bus. Arbitrates three
//                requesters (0 = IRQ ack, 1 = edit write, 2 = time refresh
//                read) with fixed priority and runs each access as an
//                address-write cycle followed by a data read or write cycle.
//  Ports       : clk      - system clock
//                reset    - synchronous, active-high
//                bus      - slave modport: req/we/addr/wdata in,
//                           rdata/done/busy out, AD/CS/RD/RW strobes,
//                           dato_out/dato_oe/dato_in for the Dato_sal tristate
//  Parameters  : T_PH (1..15) clocks per bus phase, ADDR_W = DATA_W widths
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rtc_bus_scheduler
    import rtc_bus_scheduler_pkg::*;
#(
    parameter int T_PH   = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire                clk,
    input  wire                reset,
    rtc_bus_scheduler_if.slave bus
);

    //--------------------------------------------------------------------------
    // State and latched transaction
    //--------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_idx;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic [1:0]          w_win;
    logic                w_grant;
    logic                w_load;
    logic                w_phase_end;

    // Bus outputs, decoded from state
    logic                w_ad;
    logic                w_cs;
    logic                w_rd;
    logic                w_rw;
    logic                w_oe;
    logic [DATA_W-1:0]   w_dout;
    logic [2:0]          w_done;

    assign w_win   = pick_winner(bus.req);
    assign w_grant = (r_state == S_IDLE) && (bus.req != 3'b000);

    // Any state change restarts the phase count, so every timed state lasts
    // exactly T_PH cycles.
    assign w_load = (w_state_next != r_state);

    rtc_bus_scheduler_phase_timer #(
        .T_PH (T_PH)
    ) u_phase_timer (
        .clk         (clk),
        .rst         (reset),
        .i_load      (w_load),
        .o_phase_end (w_phase_end)
    );

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)     w_state_next = S_A_SET;
            S_A_SET: if (w_phase_end) w_state_next = S_A_STB;
            S_A_STB: if (w_phase_end) w_state_next = S_A_HLD;
            S_A_HLD: if (w_phase_end) w_state_next = S_D_SET;
            S_D_SET: if (w_phase_end) w_state_next = S_D_STB;
            S_D_STB: if (w_phase_end) w_state_next = S_D_HLD;
            S_D_HLD: if (w_phase_end) w_state_next = S_DONE;
            S_DONE:                   w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Transaction latch: only the copy taken at grant is used afterwards, so
    // requesters may change or drop their inputs once granted.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= 2'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_idx   <= w_win;
            r_we    <= bus.we[w_win];
            r_addr  <= bus.addr[w_win*ADDR_W +: ADDR_W];
            r_wdata <= bus.wdata[w_win*DATA_W +: DATA_W];
        end
    end

    // Read data is sampled at the end of the strobe, when the chip has had
    // the full phase to drive Dato_sal, and held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if ((r_state == S_D_STB) && w_phase_end && !r_we) begin
            r_rdata <= bus.dato_in;
        end
    end

    //--------------------------------------------------------------------------
    // Output decode. Strobes are released in the HLD phases while the bus
    // value is still driven, giving the chip hold time. On reads the bus is
    // released from D_SET onwards so the chip never fights dato_out.
    //--------------------------------------------------------------------------
    always_comb begin
        w_ad   = 1'b1;
        w_cs   = 1'b1;
        w_rd   = 1'b1;
        w_rw   = 1'b1;
        w_oe   = 1'b0;
        w_dout = '0;
        w_done = 3'b000;
        case (r_state)
            S_A_SET: begin
                w_ad   = 1'b0;
                w_oe   = 1'b1;
                w_dout = r_addr;
            end
            S_A_STB: begin
                w_ad   = 1'b0;
                w_cs   = 1'b0;
                w_rw   = 1'b0;
                w_oe   = 1'b1;
                w_dout = r_addr;
            end
            S_A_HLD: begin
                w_ad   = 1'b0;
                w_oe   = 1'b1;
                w_dout = r_addr;
            end
            S_D_SET, S_D_HLD: begin
                if (r_we) begin
                    w_oe   = 1'b1;
                    w_dout = r_wdata;
                end
            end
            S_D_STB: begin
                w_cs = 1'b0;
                if (r_we) begin
                    w_rw   = 1'b0;
                    w_oe   = 1'b1;
                    w_dout = r_wdata;
                end else begin
                    w_rd = 1'b0;
                end
            end
            S_DONE: begin
                w_done = 3'b001 << r_idx;
            end
            default: begin
                w_ad = 1'b1;
            end
        endcase
    end

    assign bus.AD       = w_ad;
    assign bus.CS       = w_cs;
    assign bus.RD       = w_rd;
    assign bus.RW       = w_rw;
    assign bus.dato_oe  = w_oe;
    assign bus.dato_out = w_dout;
    assign bus.done     = w_done;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.rdata    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_scheduler.sv
//==============================================================================
//  Module      : tb_rtc_bus_scheduler
//  Description : Self-checking bench for rtc_bus_scheduler. A reference model
//                tracks each access as an offset into its 6*T+1 cycle
//                lifetime and derives the expected bus pins from that offset.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rtc_bus_scheduler;

    localparam int T   = 4;
    localparam int TXN = 6 * T + 1;   // offset of the done cycle

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [7:0] tb_rd_data = 8'h00;
    int   cyc = 0;

    rtc_bus_scheduler_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    // The chip drives Dato_sal only while RD is low; otherwise junk.
    assign bus.dato_in = bus.RD ? 8'hEE : tb_rd_data;

    rtc_bus_scheduler #(.T_PH(T), .ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       ad, cs, rd, rw, oe, busy;
        logic [2:0] done;
        logic [7:0] dout;
        logic [7:0] rdata;
    } obs_t;

    // Reference model: the access in flight and the cycle offset within it.
    bit         m_active  = 1'b0;
    int         m_t       = 0;
    int         m_idx     = 0;
    bit         m_we      = 1'b0;
    logic [7:0] m_addr    = 8'h00;
    logic [7:0] m_wdata   = 8'h00;
    logic [7:0] exp_rdata = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o = {bus.AD, bus.CS, bus.RD, bus.RW, bus.dato_oe, bus.busy,
             bus.done, bus.dato_out, bus.rdata};
        return o;
    endfunction

    // Phases 0..5 = A setup, A strobe, A hold, D setup, D strobe, D hold,
    // each T cycles long, then one done cycle.
    function automatic obs_t model_obs();
        obs_t o;
        int   ph;
        o.ad = 1'b1; o.cs = 1'b1; o.rd = 1'b1; o.rw = 1'b1;
        o.oe = 1'b0; o.busy = 1'b0; o.done = 3'b000; o.dout = 8'h00;
        o.rdata = exp_rdata;
        if (m_active) begin
            o.busy = 1'b1;
            if (m_t == TXN) begin
                o.done = 3'(1 << m_idx);
            end else begin
                ph     = (m_t - 1) / T;
                o.ad   = (ph >= 3);
                o.cs   = !(ph == 1 || ph == 4);
                o.rw   = !(ph == 1 || (ph == 4 && m_we));
                o.rd   = !(ph == 4 && !m_we);
                o.oe   = (ph < 3) || m_we;
                o.dout = (ph < 3) ? m_addr : (m_we ? m_wdata : 8'h00);
            end
        end
        return o;
    endfunction

    // Advance the model across the coming clock edge using the inputs the
    // bench has just set up.
    task automatic model_step();
        if (reset) begin
            m_active  = 1'b0;
            exp_rdata = 8'h00;
        end else if (!m_active) begin
            if (bus.req != 3'b000) begin
                m_idx    = bus.req[0] ? 0 : (bus.req[1] ? 1 : 2);
                m_we     = bus.we[m_idx];
                m_addr   = bus.addr[m_idx*8 +: 8];
                m_wdata  = bus.wdata[m_idx*8 +: 8];
                m_active = 1'b1;
                m_t      = 1;
            end
        end else if (m_t == TXN) begin
            m_active = 1'b0;
        end else begin
            if (m_t == 5 * T && !m_we) exp_rdata = tb_rd_data;
            m_t++;
        end
    endtask

    task automatic test_reset();
        obs_t got, exp;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = dut_obs(); exp = model_obs(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", cyc, got, exp);
            end
            if (i == 9) reset = 1'b0;
            model_step();
        end
    endtask

    task automatic test_read();
        obs_t got, exp;
        int k = 0, k_done = -1, n_addr = 0, n_rd = 0, n_cs = 0;
        bus.we = 3'b000; bus.addr = {8'h21, 8'h00, 8'h00};
        tb_rd_data = 8'h59;
        for (int i = 0; i <= TXN + 1; i++) begin
            @(negedge clk);
            got = dut_obs(); exp = model_obs(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL read cycle %0d: got %h expected %h", cyc, got, exp);
            end
            if (bus.dato_oe && bus.dato_out == 8'h21) n_addr++;
            if (!bus.RD) n_rd++;
            if (!bus.CS) n_cs++;
            if (bus.done == 3'b100) k_done = cyc - k;
            if (i == 0) begin bus.req = 3'b100; k = cyc; end
            if (m_active && m_t == TXN) bus.req = 3'b000;
            model_step();
        end
        n_checks += 5;
        if (n_addr != 12) begin n_fail++; $display("FAIL read_addr_cycles got %0d expected 12", n_addr); end
        if (n_rd != 4)    begin n_fail++; $display("FAIL read_rd_low got %0d expected 4", n_rd); end
        if (n_cs != 8)    begin n_fail++; $display("FAIL read_cs_low got %0d expected 8", n_cs); end
        if (k_done != 25) begin n_fail++; $display("FAIL read_latency got %0d expected 25", k_done); end
        if (bus.rdata !== 8'h59) begin n_fail++; $display("FAIL read_rdata got %h expected 59", bus.rdata); end
    endtask

    task automatic test_write();
        obs_t got, exp;
        int n_a = 0, n_d = 0, n_rw = 0, n_rd = 0, k = 0, k_done = -1;
        bus.we = 3'b010; bus.addr = {8'h00, 8'h22, 8'h00}; bus.wdata = {8'h00, 8'h15, 8'h00};
        for (int i = 0; i <= TXN + 1; i++) begin
            @(negedge clk);
            got = dut_obs(); exp = model_obs(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL write cycle %0d: got %h expected %h", cyc, got, exp);
            end
            if (bus.dato_oe && !bus.AD && bus.dato_out == 8'h22) n_a++;
            if (bus.dato_oe && bus.AD && bus.dato_out == 8'h15) n_d++;
            if (!bus.RW) n_rw++;
            if (!bus.RD) n_rd++;
            if (bus.done == 3'b010) k_done = cyc - k;
            if (i == 0) begin bus.req = 3'b010; k = cyc; end
            if (m_active && m_t == TXN) bus.req = 3'b000;
            model_step();
        end
        n_checks += 5;
        if (n_a != 12)    begin n_fail++; $display("FAIL write_addr_cycles got %0d expected 12", n_a); end
        if (n_d != 12)    begin n_fail++; $display("FAIL write_data_cycles got %0d expected 12", n_d); end
        if (n_rw != 8)    begin n_fail++; $display("FAIL write_rw_low got %0d expected 8", n_rw); end
        if (n_rd != 0)    begin n_fail++; $display("FAIL write_rd_low got %0d expected 0", n_rd); end
        if (k_done != 25) begin n_fail++; $display("FAIL write_latency got %0d expected 25", k_done); end
    endtask

    task automatic test_priority();
        obs_t got, exp;
        int   nd = 0;
        int   d_cyc[3];
        logic [2:0] d_val[3];
        bus.we    = 3'($urandom);
        bus.addr  = 24'($urandom);
        bus.wdata = 24'($urandom);
        tb_rd_data = 8'($urandom);
        for (int i = 0; i < 3 * (TXN + 1) + 6; i++) begin
            @(negedge clk);
            got = dut_obs(); exp = model_obs(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL priority cycle %0d: got %h expected %h", cyc, got, exp);
            end
            if (bus.done != 3'b000 && nd < 3) begin d_cyc[nd] = cyc; d_val[nd] = bus.done; nd++; end
            if (i == 0) bus.req = 3'b111;
            if (m_active && m_t == TXN) bus.req[m_idx] = 1'b0;
            model_step();
        end
        n_checks++;
        if (nd != 3) begin
            n_fail++;
            $display("FAIL priority_done_count got %0d expected 3", nd);
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (d_val[j] !== 3'(1 << j)) begin
                    n_fail++;
                    $display("FAIL priority_order slot %0d got %b expected %b", j, d_val[j], 3'(1 << j));
                end
            end
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (d_cyc[j+1] - d_cyc[j] != 26) begin
                    n_fail++;
                    $display("FAIL priority_spacing got %0d expected 26", d_cyc[j+1] - d_cyc[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        int n_done = 0, k = 0, k_done = -1;
        bus.we = 3'b010; bus.addr = {8'h30, 8'h23, 8'h00}; bus.wdata = {8'h00, 8'h47, 8'h00};
        for (int i = 0; i <= 4 * T + 8; i++) begin
            @(negedge clk);
            got = dut_obs(); exp = model_obs(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", cyc, got, exp);
            end
            if (bus.done != 3'b000) n_done++;
            if (i == 0) bus.req = 3'b010;
            if (i == 4 * T + 2) begin reset = 1'b1; bus.req = 3'b000; end
            if (i == 4 * T + 4) reset = 1'b0;
            model_step();
        end
        n_checks++;
        if (n_done != 0) begin n_fail++; $display("FAIL reset_mid_done got %0d expected 0", n_done); end
        // A fresh read must complete normally after the aborted write.
        bus.we = 3'b000; tb_rd_data = 8'hC3;
        for (int i = 0; i <= TXN + 1; i++) begin
            @(negedge clk);
            got = dut_obs(); exp = model_obs(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_read cycle %0d: got %h expected %h", cyc, got, exp);
            end
            if (bus.done == 3'b100) k_done = cyc - k;
            if (i == 0) begin bus.req = 3'b100; k = cyc; end
            if (m_active && m_t == TXN) bus.req = 3'b000;
            model_step();
        end
        n_checks += 2;
        if (k_done != 25) begin n_fail++; $display("FAIL reset_mid_read_latency got %0d expected 25", k_done); end
        if (bus.rdata !== 8'hC3) begin n_fail++; $display("FAIL reset_mid_rdata got %h expected c3", bus.rdata); end
    endtask

    task automatic test_drop_req();
        obs_t got, exp;
        int k = 0, k_done = -1;
        bus.we = 3'b001; bus.addr = {8'h00, 8'h00, 8'h40}; bus.wdata = {8'h00, 8'h00, 8'h7E};
        for (int i = 0; i <= TXN + 1; i++) begin
            @(negedge clk);
            got = dut_obs(); exp = model_obs(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL drop_req cycle %0d: got %h expected %h", cyc, got, exp);
            end
            if (bus.done == 3'b001) k_done = cyc - k;
            if (i == 0) begin bus.req = 3'b001; k = cyc; end
            if (i == T + 1) begin
                // Drop the request in A_STB and scramble the lanes.
                bus.req = 3'b000; bus.we = 3'b000;
                bus.addr = 24'($urandom); bus.wdata = 24'($urandom);
            end
            model_step();
        end
        n_checks++;
        if (k_done != 25) begin n_fail++; $display("FAIL drop_req_latency got %0d expected 25", k_done); end
    endtask

    task automatic test_random();
        obs_t got, exp;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            got = dut_obs(); exp = model_obs(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", cyc, got, exp);
            end
            reset = (($urandom % 500) == 0);
            for (int r = 0; r < 3; r++) begin
                if (m_active && m_t == TXN && m_idx == r) begin
                    bus.req[r] = 1'b0;
                end else if (!bus.req[r] && ($urandom % 6) == 0) begin
                    bus.req[r]          = 1'b1;
                    bus.we[r]           = 1'($urandom);
                    bus.addr[r*8 +: 8]  = 8'($urandom);
                    bus.wdata[r*8 +: 8] = 8'($urandom);
                end else if (bus.req[r] && ($urandom % 60) == 0) begin
                    bus.req[r] = 1'b0;
                end else if (($urandom % 8) == 0) begin
                    bus.addr[r*8 +: 8]  = 8'($urandom);
                    bus.wdata[r*8 +: 8] = 8'($urandom);
                end
            end
            if (!m_active) tb_rd_data = 8'($urandom);
            model_step();
        end
    endtask

    initial begin
        bus.req = 3'b000; bus.we = 3'b000; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
